output_port_tx: RTL and testbench

- Transmit side of a router output port in the mesh NoC.
- Watches the head flits of all input FIFOs and selects, by round-robin, those whose target field matches this port.
- Pops the winning FIFO and drives the selected flit onto the outgoing link.
- Uses a credit counter so it never overruns the 5-entry input FIFO at the far end of the link.

---
 rtl/output_port_tx.sv | 91 +++++++++
 tb/tb_output_port_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/output_port_tx.sv
// Transmit side of a NoC router output port: round-robin selection of
// matching input-FIFO heads, one-cycle registered link, credit flow control.
module output_port_tx #(
    parameter int NUM_IN  = 5,
    parameter int FLIT_W  = 23,
    parameter int PORT_ID = 0,
    parameter int CREDITS = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*FLIT_W-1:0]     head_flat,
    input  logic [NUM_IN-1:0]            head_valid,
    output logic [NUM_IN-1:0]            pop,
    output logic [FLIT_W-1:0]            tx_flit,
    output logic                         tx_valid,
    input  logic                         credit_return,
    output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
    output logic                         credit_err
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CNT_W = $clog2(CREDITS + 1);
    localparam logic [2:0]       PID     = 3'(PORT_ID);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CREDITS);
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_IN - 1);

    logic [FLIT_W-1:0] head [NUM_IN];
    logic [NUM_IN-1:0] req;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  win;
    logic              found;
    logic              grant;
    int                idx;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_req
        assign head[g] = head_flat[g*FLIT_W +: FLIT_W];
        assign req[g]  = head_valid[g] && (head[g][2:0] == PID);
    end

    // Search starts just past the last winner and wraps around.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = (int'(ptr) + k) % NUM_IN;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    assign grant = rst && found && (credit_cnt != '0);
    assign pop   = grant ? (NUM_IN'(1) << win) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_flit  <= '0;
            tx_valid <= 1'b0;
            ptr      <= PTR_RST;
        end else if (grant) begin
            tx_flit  <= head[win];
            tx_valid <= 1'b1;
            ptr      <= win;
        end else begin
            tx_flit  <= '0;
            tx_valid <= 1'b0;
        end
    end

    // A return with the count already full is a protocol error; hold the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_cnt <= MAX_CNT;
            credit_err <= 1'b0;
        end else begin
            case ({grant, credit_return})
                2'b10: credit_cnt <= credit_cnt - 1'b1;
                2'b01: begin
                    if (credit_cnt == MAX_CNT)
                        credit_err <= 1'b1;
                    else
                        credit_cnt <= credit_cnt + 1'b1;
                end
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_output_port_tx.sv
// Directed testbench for output_port_tx (PORT_ID=2).
module tb_output_port_tx;

    localparam int NUM_IN = 5;
    localparam int FLIT_W = 23;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_IN*FLIT_W-1:0] head_flat;
    logic [NUM_IN-1:0]        head_valid;
    logic [NUM_IN-1:0]        pop;
    logic [FLIT_W-1:0]        tx_flit;
    logic                     tx_valid;
    logic                     credit_return;
    logic [2:0]               credit_cnt;
    logic                     credit_err;

    int n_tests = 0;
    int n_fail  = 0;

    output_port_tx #(
        .NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .PORT_ID(2), .CREDITS(5)
    ) dut (
        .clk(clk), .rst(rst),
        .head_flat(head_flat), .head_valid(head_valid),
        .pop(pop), .tx_flit(tx_flit), .tx_valid(tx_valid),
        .credit_return(credit_return),
        .credit_cnt(credit_cnt), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [FLIT_W-1:0] mk(input logic [15:0] d,
                                             input logic [3:0] a,
                                             input logic [2:0] t);
        return {d, a, t};
    endfunction

    task automatic set_head(input int i, input logic [FLIT_W-1:0] f);
        head_flat[i*FLIT_W +: FLIT_W] = f;
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        head_valid    = '0;
        head_flat     = '0;
        credit_return = 1'b0;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    logic [FLIT_W-1:0] rr_flit [NUM_IN];
    int                rr_seq [6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        rst           = 1'b0;
        head_flat     = '0;
        head_valid    = '0;
        credit_return = 1'b0;

        // Reset with random inputs
        for (int c = 0; c < 3; c++) begin
            head_flat     = {$urandom, $urandom, $urandom, $urandom};
            head_valid    = NUM_IN'($urandom);
            credit_return = 1'($urandom);
            #4;
            check("rst_pop", 32'(pop), 32'(0));
            cyc();
        end
        check("rst_txv", 32'(tx_valid), 32'(0));
        check("rst_txf", 32'(tx_flit), 32'(0));
        check("rst_cnt", 32'(credit_cnt), 32'(5));
        check("rst_err", 32'(credit_err), 32'(0));

        // Single flit
        do_reset();
        set_head(2, 23'h55E6AA);
        head_valid = 5'b00100;
        #4;
        check("sf_pop", 32'(pop), 32'(5'b00100));
        cyc();
        head_valid = '0;
        #4;
        check("sf_txv", 32'(tx_valid), 32'(1));
        check("sf_txf", 32'(tx_flit), 32'(23'h55E6AA));
        check("sf_cnt", 32'(credit_cnt), 32'(4));
        check("sf_pop0", 32'(pop), 32'(0));
        cyc();
        #4;
        check("sf_txv0", 32'(tx_valid), 32'(0));

        // Round robin over inputs 0,1,3 with a return every cycle
        do_reset();
        for (int i = 0; i < NUM_IN; i++) begin
            rr_flit[i] = mk(16'h1000 + 16'(i), 4'(i), 3'd2);
            set_head(i, rr_flit[i]);
        end
        head_valid    = 5'b01011;
        credit_return = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #4;
            check("rr_pop", 32'(pop), 32'(1) << rr_seq[k]);
            check("rr_cnt", 32'(credit_cnt), 32'(5));
            if (k > 0) begin
                check("rr_txv", 32'(tx_valid), 32'(1));
                check("rr_txf", 32'(tx_flit), 32'(rr_flit[rr_seq[k-1]]));
            end
            cyc();
        end
        head_valid    = '0;
        credit_return = 1'b0;
        #4;
        check("rr_err", 32'(credit_err), 32'(0));

        // Target filter
        do_reset();
        set_head(1, mk(16'h1234, 4'h7, 3'd4));
        head_valid = 5'b00010;
        for (int k = 0; k < 10; k++) begin
            #4;
            check("tf_pop", 32'(pop), 32'(0));
            check("tf_txv", 32'(tx_valid), 32'(0));
            cyc();
        end

        // Credit exhaustion
        do_reset();
        set_head(0, mk(16'hBEEF, 4'h1, 3'd2));
        head_valid = 5'b00001;
        for (int k = 0; k < 5; k++) begin
            #4;
            check("ce_pop", 32'(pop), 32'(1));
            check("ce_cnt", 32'(credit_cnt), 32'(5 - k));
            cyc();
        end
        #4;
        check("ce_pop0", 32'(pop), 32'(0));
        check("ce_txv_last", 32'(tx_valid), 32'(1));
        check("ce_cnt0", 32'(credit_cnt), 32'(0));
        cyc();
        #4;
        check("ce_txv0", 32'(tx_valid), 32'(0));
        check("ce_pop0b", 32'(pop), 32'(0));
        cyc();
        credit_return = 1'b1;
        #4;
        check("ce_ret_pop", 32'(pop), 32'(0));
        cyc();
        credit_return = 1'b0;
        #4;
        check("ce_cnt1", 32'(credit_cnt), 32'(1));
        check("ce_pop1", 32'(pop), 32'(1));
        cyc();
        #4;
        check("ce_cnt_end", 32'(credit_cnt), 32'(0));
        check("ce_pop_end", 32'(pop), 32'(0));
        check("ce_txv_end", 32'(tx_valid), 32'(1));

        // Overflow
        do_reset();
        credit_return = 1'b1;
        cyc();
        credit_return = 1'b0;
        #4;
        check("of_err", 32'(credit_err), 32'(1));
        check("of_cnt", 32'(credit_cnt), 32'(5));

        // Mid-operation reset
        set_head(0, mk(16'hCAFE, 4'h2, 3'd2));
        head_valid = 5'b00001;
        cyc();
        cyc();
        #4;
        check("mr_txv_pre", 32'(tx_valid), 32'(1));
        rst = 1'b0;
        #1;
        check("mr_txv", 32'(tx_valid), 32'(0));
        check("mr_txf", 32'(tx_flit), 32'(0));
        check("mr_pop", 32'(pop), 32'(0));
        check("mr_cnt", 32'(credit_cnt), 32'(5));
        check("mr_err", 32'(credit_err), 32'(0));
        cyc();
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
